// File: rtl/crc_frame_appender.sv
// Streaming CRC appender: frames pass through byte by byte and the frame CRC
// is appended after the last payload byte. crc_calc is the generic CRC engine.

module crc_calc #(
  parameter logic [63:0] POLY       = 64'h8005,
  parameter int unsigned CRC_SIZE   = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [63:0] INIT       = 64'h0000,
  parameter bit          REF_IN     = 1'b1,
  parameter bit          REF_OUT    = 1'b1,
  parameter logic [63:0] XOR_OUT    = 64'hffff
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  soft_reset_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_SIZE-1:0]   crc_o
);

  localparam logic [CRC_SIZE-1:0] POLY_W = POLY[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0] INIT_W = INIT[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0] XOR_W  = XOR_OUT[CRC_SIZE-1:0];

  logic [CRC_SIZE-1:0] crc_q, crc_d, crc_rev;
  logic                bit_in, fb;

  // Register holds the unreflected MSB-first remainder; input reflection only
  // changes the order in which data bits are shifted in.
  always_comb begin
    crc_d  = crc_q;
    bit_in = 1'b0;
    fb     = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      bit_in = REF_IN ? data_i[i] : data_i[DATA_WIDTH-1-i];
      fb     = crc_d[CRC_SIZE-1] ^ bit_in;
      crc_d  = {crc_d[CRC_SIZE-2:0], 1'b0} ^ (fb ? POLY_W : '0);
    end
  end

  always_comb begin
    crc_rev = '0;
    for (int unsigned i = 0; i < CRC_SIZE; i++) begin
      crc_rev[i] = crc_q[CRC_SIZE-1-i];
    end
    crc_o = (REF_OUT ? crc_rev : crc_q) ^ XOR_W;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || soft_reset_i) begin
      crc_q <= INIT_W;
    end else if (valid_i) begin
      crc_q <= crc_d;
    end
  end

endmodule

module crc_frame_appender #(
  parameter logic [63:0] POLY      = 64'h8005,
  parameter int unsigned CRC_SIZE  = 16,
  parameter logic [63:0] INIT      = 64'h0000,
  parameter bit          REF_IN    = 1'b1,
  parameter bit          REF_OUT   = 1'b1,
  parameter logic [63:0] XOR_OUT   = 64'hffff,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [7:0]  s_data_i,
  input  logic        s_last_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [7:0]  m_data_o,
  output logic        m_last_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned NBYTES   = CRC_SIZE / 8;
  localparam logic [2:0]  LAST_IDX = 3'(NBYTES - 1);

  typedef enum logic {ST_DATA, ST_APPEND} state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d, sel;
  logic                m_valid_d, m_last_d;
  logic [7:0]          m_data_d, crc_byte;
  logic [15:0]         cnt_d;
  logic                out_free, crc_valid, crc_soft_rst;
  logic [CRC_SIZE-1:0] crc;

  crc_calc #(
    .POLY       (POLY),
    .CRC_SIZE   (CRC_SIZE),
    .DATA_WIDTH (8),
    .INIT       (INIT),
    .REF_IN     (REF_IN),
    .REF_OUT    (REF_OUT),
    .XOR_OUT    (XOR_OUT)
  ) u_crc (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .soft_reset_i (crc_soft_rst),
    .valid_i      (crc_valid),
    .data_i       (s_data_i),
    .crc_o        (crc)
  );

  // MSB-first order is the LSB-first byte index mirrored.
  always_comb begin
    sel      = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
    crc_byte = 8'(crc >> {sel, 3'b000});
  end

  always_comb begin
    out_free     = !m_valid_o || m_ready_i;
    state_d      = state_q;
    idx_d        = idx_q;
    m_valid_d    = m_valid_o;
    m_data_d     = m_data_o;
    m_last_d     = m_last_o;
    cnt_d        = frame_cnt_o;
    s_ready_o    = 1'b0;
    busy_o       = 1'b0;
    crc_valid    = 1'b0;
    crc_soft_rst = 1'b0;
    case (state_q)
      ST_DATA: begin
        s_ready_o = out_free;
        if (s_valid_i && out_free) begin
          m_data_d  = s_data_i;
          m_last_d  = 1'b0;
          m_valid_d = 1'b1;
          crc_valid = 1'b1;
          if (s_last_i) begin
            state_d = ST_APPEND;
            idx_d   = '0;
          end
        end else if (out_free) begin
          m_valid_d = 1'b0;
        end
      end
      ST_APPEND: begin
        busy_o = 1'b1;
        if (out_free) begin
          m_data_d  = crc_byte;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          idx_d     = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
            m_last_d     = 1'b1;
            crc_soft_rst = 1'b1;
            cnt_d        = frame_cnt_o + 16'd1;
            state_d      = ST_DATA;
          end
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_DATA;
      idx_q       <= '0;
      m_valid_o   <= 1'b0;
      m_data_o    <= '0;
      m_last_o    <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      m_valid_o   <= m_valid_d;
      m_data_o    <= m_data_d;
      m_last_o    <= m_last_d;
      frame_cnt_o <= cnt_d;
    end
  end

endmodule

// File: tb/tb_crc_frame_appender.sv
// Bench for crc_frame_appender: two instances (LSB-first and MSB-first CRC
// order) share one input stream; outputs are scored against a CRC-16/MAXIM model.

module tb_crc_frame_appender;

  typedef struct {
    int          len;
    logic [7:0]  data [16];
    logic [15:0] crc;
    bit          bp;
  } vec_t;

  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1, bp_en = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready [2], m_valid [2], m_last [2], busy [2];
  logic [7:0]  m_data [2];
  logic [15:0] fcnt [2];

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  logic [8:0] exp_q0 [$];
  logic [8:0] exp_q1 [$];
  logic       prev_stall [2] = '{1'b0, 1'b0};
  logic [8:0] prev_out [2];
  logic [8:0] mon_got, mon_exp;
  vec_t       vecs [NV];

  always #5 clk = ~clk;

  crc_frame_appender #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready[0]),
    .s_data_i(s_data), .s_last_i(s_last), .m_valid_o(m_valid[0]),
    .m_ready_i(m_ready), .m_data_o(m_data[0]), .m_last_o(m_last[0]),
    .busy_o(busy[0]), .frame_cnt_o(fcnt[0])
  );

  crc_frame_appender #(.LSB_FIRST(1'b0)) dut_msb (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready[1]),
    .s_data_i(s_data), .s_last_i(s_last), .m_valid_o(m_valid[1]),
    .m_ready_i(m_ready), .m_data_o(m_data[1]), .m_last_o(m_last[1]),
    .busy_o(busy[1]), .frame_cnt_o(fcnt[1])
  );

  // Downstream ready changes late in the cycle so it never races bp_en updates.
  always @(posedge clk) begin
    #2;
    m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (prev_stall[d]) begin
        total++;
        if (!(m_valid[d] === 1'b1 && {m_last[d], m_data[d]} === prev_out[d])) begin
          bad++;
          $display("FAIL stall_hold dut%0d: got v=%b %h want v=1 %h", d, m_valid[d],
                   {m_last[d], m_data[d]}, prev_out[d]);
        end
      end
      if (m_valid[d] === 1'b1 && m_ready === 1'b1) begin
        mon_got = {m_last[d], m_data[d]};
        total++;
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          bad++;
          $display("FAIL extra_byte dut%0d: got %h want none", d, mon_got);
        end else begin
          if (d == 0) mon_exp = exp_q0.pop_front();
          else        mon_exp = exp_q1.pop_front();
          if (mon_got !== mon_exp) begin
            bad++;
            $display("FAIL out_byte dut%0d: got last,data=%h want %h", d, mon_got, mon_exp);
          end
        end
      end
      prev_stall[d] = (m_valid[d] === 1'b1) && (m_ready === 1'b0) && !rst;
      prev_out[d]   = {m_last[d], m_data[d]};
    end
    if (busy[0] === 1'b1) busy_cnt++;
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reflected bit-serial CRC-16/MAXIM: init 0, reversed poly 0xA001, xorout 0xFFFF.
  function automatic logic [15:0] model_crc(input vec_t v);
    logic [15:0] c = 16'h0000;
    for (int i = 0; i < v.len; i++) begin
      c = c ^ {8'h00, v.data[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c ^ 16'hFFFF;
  endfunction

  task automatic push_frame(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      exp_q0.push_back({1'b0, v.data[i]});
      exp_q1.push_back({1'b0, v.data[i]});
    end
    exp_q0.push_back({1'b0, v.crc[7:0]});
    exp_q0.push_back({1'b1, v.crc[15:8]});
    exp_q1.push_back({1'b0, v.crc[15:8]});
    exp_q1.push_back({1'b1, v.crc[7:0]});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, output int stalls);
    stalls  = 0;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    forever begin
      @(negedge clk);
      if (s_ready[0] === 1'b1) break;
      stalls++;
      if (stalls > 1000) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got s_ready=%b want 1 within 1000 cycles", s_ready[0]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input vec_t v, output int first_stall);
    int st;
    first_stall = 0;
    bp_en = v.bp;
    push_frame(v);
    for (int i = 0; i < v.len; i++) begin
      send_byte(v.data[i], 1'(i == v.len - 1), st);
      if (i == 0) first_stall = st;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 16'(exp_q0.size() + exp_q1.size()), 16'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] msg [9];
    vec_t v;
    int   st;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_m_valid%0d", d), 16'(m_valid[d]), 16'd0);
      check($sformatf("rst_m_data%0d", d), 16'(m_data[d]), 16'd0);
      check($sformatf("rst_m_last%0d", d), 16'(m_last[d]), 16'd0);
      check($sformatf("rst_busy%0d", d), 16'(busy[d]), 16'd0);
      check($sformatf("rst_fcnt%0d", d), fcnt[d], 16'd0);
      check($sformatf("rst_s_ready%0d", d), 16'(s_ready[d]), 16'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table: check string twice back-to-back, once under backpressure, then random frames.
    for (int k = 0; k < NV; k++) begin
      for (int j = 0; j < 16; j++) vecs[k].data[j] = '0;
      if (k < 3) begin
        vecs[k].len = 9;
        for (int j = 0; j < 9; j++) vecs[k].data[j] = msg[j];
        vecs[k].crc = 16'h44C2;
        vecs[k].bp  = (k == 2);
      end else begin
        vecs[k].len = $urandom_range(1, 12);
        for (int j = 0; j < vecs[k].len; j++) vecs[k].data[j] = 8'($urandom);
        vecs[k].crc = model_crc(vecs[k]);
        vecs[k].bp  = 1'($urandom_range(0, 1));
      end
    end

    for (int k = 0; k < NV; k++) begin
      send_frame(vecs[k], st);
      if (k == 0) check("first_stall", 16'(st), 16'd0);
      else if (!vecs[k].bp && !vecs[k-1].bp)
        check($sformatf("gap_cycles%0d", k), 16'(st), 16'd2);
    end
    bp_en = 1'b0;
    drain();
    check("fcnt_lsb_table", fcnt[0], 16'(NV));
    check("fcnt_msb_table", fcnt[1], 16'(NV));

    // Single 0x00 byte: latency, busy duration, model CRC.
    v.len = 1;
    for (int j = 0; j < 16; j++) v.data[j] = '0;
    v.crc = model_crc(v);
    v.bp  = 1'b0;
    push_frame(v);
    busy_cnt = 0;
    send_byte(8'h00, 1'b1, st);
    @(negedge clk);
    check("latency_valid", 16'(m_valid[0]), 16'd1);
    check("latency_data", 16'(m_data[0]), 16'h0000);
    repeat (6) @(negedge clk);
    check("busy_cycles", 16'(busy_cnt), 16'd2);
    drain();
    check("fcnt_single", fcnt[0], 16'(NV + 1));

    // Abort a frame with reset after 4 bytes; no CRC may follow it.
    for (int j = 0; j < 4; j++) begin
      v.data[j] = 8'($urandom);
      exp_q0.push_back({1'b0, v.data[j]});
      exp_q1.push_back({1'b0, v.data[j]});
      send_byte(v.data[j], 1'b0, st);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_m_valid", 16'(m_valid[0]), 16'd0);
    check("abort_busy", 16'(busy[0]), 16'd0);
    check("abort_fcnt", fcnt[0], 16'd0);
    check("abort_queue", 16'(exp_q0.size() + exp_q1.size()), 16'd0);
    @(posedge clk);
    #1;
    send_frame(vecs[0], st);
    drain();
    check("post_abort_fcnt_lsb", fcnt[0], 16'd1);
    check("post_abort_fcnt_msb", fcnt[1], 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_frame_appender.md
Name: crc_frame_appender

Overview:
Streaming CRC generator controller. It sequences a crc_calc instance over byte-wide frames. Each input frame passes through to the output unchanged, and the final CRC is appended as CRC_SIZE/8 bytes after the last payload byte. It sits between a packet source and the line/serializer side and owns the crc_calc soft-reset and valid sequencing.

Parameters:
POLY, 64'h8005, generator polynomial; passed to crc_calc.
CRC_SIZE, 16, CRC width in bits; must be a multiple of 8, range 8..64.
INIT, 64'h0000, CRC initial value; passed to crc_calc.
REF_IN, 1, input reflection; passed to crc_calc.
REF_OUT, 1, output reflection; passed to crc_calc.
XOR_OUT, 64'hffff, final XOR; passed to crc_calc.
LSB_FIRST, 1, 1 = append CRC least-significant byte first; 0 = most-significant byte first.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
s_valid_i  in  1  input byte valid
s_ready_o  out  1  input byte accepted when s_valid_i && s_ready_o
s_data_i  in  8  input payload byte
s_last_i  in  1  marks last payload byte of frame
m_valid_o  out  1  output byte valid
m_ready_i  in  1  downstream ready
m_data_o  out  8  output byte (payload or CRC)
m_last_o  out  1  marks last CRC byte of frame
busy_o  out  1  1 while in APPEND state
frame_cnt_o  out  16  count of fully emitted frames, wraps 16'hffff -> 0

Behaviour:
- One clock domain; everything registered on posedge clk_i. Internal crc_calc uses DATA_WIDTH=8 and the parameters above.
- Reset (rst_i=1): state=DATA, m_valid_o=0, m_data_o=0, m_last_o=0, busy_o=0, frame_cnt_o=0, byte index=0. crc_calc also reset via rst_i, so CRC=INIT. A reset mid-frame or mid-append discards the frame; no partial CRC is emitted.
- Output stage: single register. out_free = !m_valid_o || m_ready_i. The m_* outputs hold stable while m_valid_o && !m_ready_i.
- State DATA:
  - s_ready_o = out_free.
  - On accept: m_data_o<=s_data_i, m_last_o<=0, m_valid_o<=1, and crc_calc valid_i=1 with data_i=s_data_i in the same cycle.
  - If s_last_i on accept: go to APPEND, byte index<=0.
  - If out_free and no accept: m_valid_o<=0.
- State APPEND:
  - s_ready_o=0; busy_o=1; crc_calc valid_i=0, so crc_o holds the final value. The final value is valid from the first APPEND cycle because the CRC register updates on the same edge that enters APPEND.
  - When out_free: load CRC byte k (k = byte index) with m_valid_o<=1.
    - LSB_FIRST=1: byte k = crc_o[8k+7:8k].
    - LSB_FIRST=0: byte k = crc_o[CRC_SIZE-1-8k -: 8].
    - Then index++.
  - On loading the last CRC byte (k = CRC_SIZE/8-1):
    - m_last_o<=1.
    - crc_calc soft_reset_i=1 for that cycle, so CRC returns to INIT.
    - frame_cnt_o++.
    - state<=DATA.
- soft_reset_i is asserted only in that cycle, and never together with valid_i.
- Latency: a payload byte appears on m_data_o one cycle after acceptance.
- Throughput: 1 byte/cycle during payload. Inter-frame bubble on the input is exactly CRC_SIZE/8 cycles when m_ready_i is held 1.
- A single-byte frame (s_last_i on the first byte) is legal. Zero-length frames cannot be expressed.
- Back-to-back: the first byte of the next frame may be accepted the cycle after the last CRC byte is loaded, and it is computed from INIT.

Test Plan:
- Defaults (CRC-16/MAXIM), ASCII "123456789", m_ready_i=1 -> output is the 9 bytes then 8'hC2, 8'h44; m_last_o only on 8'h44; frame_cnt_o=1.
- Same frame, LSB_FIRST=0 -> CRC bytes 8'h44 then 8'hC2.
- Two back-to-back "123456789" frames -> both CRCs are 16'h44C2 (soft reset verified); s_ready_o low for exactly 2 cycles between frames.
- Random m_ready_i backpressure (50%) on the same frame -> identical byte sequence; no byte dropped or duplicated; m_* stable while stalled.
- Single byte 8'h00 -> payload 8'h00, then CRC bytes match the bench's bit-serial model of CRC-16/MAXIM for that byte; busy_o high for the 2 append cycles.
- rst_i pulsed after 4 payload bytes, then full "123456789" -> no CRC emitted for the aborted frame; new frame CRC = 16'h44C2; frame_cnt_o=1.
